// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer. The owner keeps the
// grant while it requests and is force-released, with a timeout pulse, after MAX_HOLD cycles.
module rr_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IW:0]   N_EXT    = (IW + 1)'(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    ptr, ptr_nxt;
    logic [N-1:0]    grant_nxt;
    logic [IW-1:0]   grant_id_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            timeout_nxt;
    logic [IW-1:0]   ptr_idx;
    logic [2*N-1:0]  dbl;
    logic [IW-1:0]   off;
    logic [IW:0]     sum;
    logic [IW-1:0]   sel;
    logic            found;
    logic            owner_req;

    always_comb begin : ptr_decode
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) ptr_idx = IW'(i);
        end
    end

    // Rotate req so the pointer position lands at bit 0; the first set bit is the
    // winner's distance from the pointer, which wraps back to an absolute index.
    always_comb begin : pick
        dbl   = {req, req} >> ptr_idx;
        off   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && dbl[j]) begin
                found = 1'b1;
                off   = IW'(j);
            end
        end
        sum = {1'b0, ptr_idx} + {1'b0, off};
        if (sum >= N_EXT) sum = sum - N_EXT;
        sel = sum[IW-1:0];
    end

    always_comb begin : next_state
        state_nxt    = state;
        ptr_nxt      = ptr;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        hold_nxt     = hold_cnt;
        timeout_nxt  = 1'b0;
        owner_req    = |(req & grant);
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = BUSY;
                    grant_nxt    = {{(N-1){1'b0}}, 1'b1} << sel;
                    grant_id_nxt = sel;
                    hold_nxt     = HW'(1);
                end
            end
            BUSY: begin
                if (!owner_req || hold_cnt == HOLD_MAX) begin
                    state_nxt    = IDLE;
                    grant_nxt    = '0;
                    grant_id_nxt = '0;
                    hold_nxt     = '0;
                    // Rotating the one-hot grant gives onehot(owner+1) with wrap.
                    ptr_nxt      = {grant[N-2:0], grant[N-1]};
                    timeout_nxt  = owner_req;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            ptr      <= N'(1);
            grant    <= '0;
            grant_id <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            grant_id <= grant_id_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter (N=4, MAX_HOLD=4): directed vectors push the
// expected post-edge response; a monitor pops and compares it on every falling edge.
module tb_rr_grant_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] grant_id;
        logic       busy;
        logic       timeout;
    } resp_t;

    resp_t exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  done  = 1'b0;
    resp_t e;
    resp_t act;
    string nm;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    function automatic resp_t mk(input logic [3:0] g, input logic t);
        resp_t r;
        r.grant    = g;
        r.grant_id = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) r.grant_id = 2'(i);
        end
        r.busy    = |g;
        r.timeout = t;
        return r;
    endfunction

    // Drive one vector for n cycles; expected values describe the outputs after each edge.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] g,
                         input logic t, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            rstn = r;
            req  = rq;
            exp_q.push_back(mk(g, t));
            name_q.push_back(name);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = '{grant, grant_id, busy, timeout};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s @%0t: got grant=%b id=%0d busy=%b timeout=%b, want grant=%b id=%0d busy=%b timeout=%b",
                         nm, $time, act.grant, act.grant_id, act.busy, act.timeout,
                         e.grant, e.grant_id, e.busy, e.timeout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] oh;
        rstn = 1'b0;
        req  = '0;

        // Reset with all requesting, then the first grant goes to requester 0.
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 2, "reset");
        drive(1'b1, 4'b1111, 4'b0001, 1'b0, 1, "first_grant");
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1, "t1_release");

        // Normal handoff 0 -> 2 with one idle cycle between.
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1, "reset2");
        drive(1'b1, 4'b0101, 4'b0001, 1'b0, 2, "t2_grant0");
        drive(1'b1, 4'b0100, 4'b0000, 1'b0, 1, "t2_release0");
        drive(1'b1, 4'b0100, 4'b0100, 1'b0, 1, "t2_grant2");

        // Wrap-around: ptr=1000 after owner 2 leaves, so 3 beats 0.
        drive(1'b1, 4'b1001, 4'b0000, 1'b0, 1, "t4_release2");
        drive(1'b1, 4'b1001, 4'b1000, 1'b0, 4, "t4_wrap_grant3");
        drive(1'b1, 4'b1001, 4'b0000, 1'b1, 1, "t4_timeout3");
        drive(1'b1, 4'b1001, 4'b0001, 1'b0, 1, "t4_grant0");
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1, "t4_release0");

        // All requesting for 25 cycles: 4 granted + 1 timeout idle per owner.
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1, "reset3");
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            drive(1'b1, 4'b1111, oh,      1'b0, 4, "t3_rotate_grant");
            drive(1'b1, 4'b1111, 4'b0000, 1'b1, 1, "t3_timeout");
        end

        // Lone requester is re-granted after each forced release.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4'b0010, 4'b0010, 1'b0, 4, "t5_lone_grant");
            drive(1'b1, 4'b0010, 4'b0000, 1'b1, 1, "t5_lone_timeout");
        end
        drive(1'b1, 4'b0010, 4'b0010, 1'b0, 2, "t5_lone_grant");

        // Reset mid-grant drops the grant and restores ptr to requester 0.
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1, "t6_release1");
        drive(1'b1, 4'b0100, 4'b0100, 1'b0, 2, "t6_grant2");
        drive(1'b0, 4'b0100, 4'b0000, 1'b0, 1, "t6_reset_mid");
        drive(1'b1, 4'b0101, 4'b0001, 1'b0, 1, "t6_ptr_reset");
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1, "t6_release0");

        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters using a one-hot rotating priority pointer.
- Sequences ownership: grants one requester, holds the grant while that requester keeps requesting, and force-releases it after MAX_HOLD cycles.
- After each release the priority pointer advances to the requester just after the previous owner.

Parameters:
- N, 4, number of requesters; legal values are N >= 2.
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; legal values are MAX_HOLD >= 1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rstn  input  1  synchronous, active-low reset.
- req  input  N  level request per requester; bit i belongs to requester i.
- grant  output  N  registered one-hot grant; all zeros when nobody owns the resource.
- grant_id  output  $clog2(N)  binary index of the granted requester; 0 when grant is zero.
- busy  output  1  high while in BUSY state; equals |grant.
- timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (rstn low at posedge):
  - grant=0, grant_id=0, busy=0, timeout=0.
  - ptr (internal one-hot priority) = 1, so requester 0 has highest priority.
  - hold_cnt=0, state=IDLE.
  - Reset overrides everything, including mid-grant. The grant drops on the reset edge and the pointer is not preserved.
- Internal state:
  - ptr is N-bit one-hot, always exactly one bit set.
  - hold_cnt is $clog2(MAX_HOLD+1) bits and saturates at MAX_HOLD.
- IDLE state:
  - If req==0: stay in IDLE with no output change.
  - Otherwise: select the first set req bit searching from the ptr position upward, wrapping from N-1 to 0.
  - On that edge: grant <= onehot(sel), grant_id <= sel, busy <= 1, hold_cnt <= 1, state <= BUSY.
  - Latency: req is sampled at edge t and grant is visible after edge t.
- BUSY state (owner = grant_id):
  - Release on any edge where req[owner]==0 (normal release), or where req[owner]==1 and hold_cnt==MAX_HOLD (forced release).
  - On release: grant <= 0, grant_id <= 0, busy <= 0, state <= IDLE, and ptr <= onehot((owner+1) mod N).
  - Forced release also sets timeout <= 1 for exactly one cycle. timeout is 0 in every other cycle.
  - Otherwise: hold_cnt <= hold_cnt+1 and the grant is unchanged.
  - Requests from non-owners are ignored while BUSY.
- Grant timing:
  - Each grant lasts at most MAX_HOLD cycles.
  - At least one grant-free cycle follows every release; no back-to-back grant handover.
- Pointer rotation:
  - Rotation wraps from bit N-1 back to bit 0.
  - ptr changes only on release, never in IDLE and never on arbitration.
- Invariants:
  - grant is one-hot or zero.
  - busy == |grant.
  - grant_id matches grant.
  - ptr is one-hot.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,...,N-1,0 and each is force-released after MAX_HOLD cycles.
- A requester that re-raises req during its own release cycle is not re-granted ahead of higher-priority pending requesters. It competes from the new ptr.

Test Plan (N=4, MAX_HOLD=4):
1. Reset: hold rstn=0 for 2 cycles with req=1111 -> grant=0000, busy=0, timeout=0. First grant after reset release is 0001.
2. Normal handoff: req=0101 -> grant=0001 next cycle. Drop req[0] after 2 grant cycles -> grant=0000 for one cycle, then 0100 (grant_id=2), timeout stays 0.
3. Timeout and rotation: req=1111 held for 25 cycles -> grant sequence 0001,0010,0100,1000,0001. Each grant lasts 4 cycles, then 1 idle cycle with a timeout pulse on each release edge.
4. Wrap-around: after owner 2 releases (ptr=1000), apply req=1001 -> grant=1000 first. After its release -> grant=0001.
5. Lone requester: req=0010 held 12 cycles -> repeating pattern of 4 cycles granted, 1 cycle idle with timeout=1, then re-granted to 0010.
6. Reset mid-grant: assert rstn=0 during cycle 2 of grant=0100 -> grant=0000 on that edge. After reset with req=0101 -> grant=0001 (ptr back to 1).
